// File: rtl/instruction_fetch_responder_pkg.sv
// Shared definitions for the instruction fetch responder: FSM states and width helpers.
package instruction_fetch_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    RESPOND = 2'd2
  } state_e;

  // Index width for n entries; a single entry still needs one bit of storage.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Beat counters must be able to hold the value Beats itself.
  function automatic int unsigned cnt_width(input int unsigned beats);
    return $clog2(beats + 1);
  endfunction

endpackage

// File: rtl/instruction_fetch_responder_rr_arb.sv
// Round-robin arbiter: grants the first requester after the last one served.
module instruction_fetch_responder_rr_arb
  import instruction_fetch_responder_pkg::*;
#(
  parameter  int unsigned NumIn     = 8,
  parameter  int unsigned DataWidth = 32,
  localparam int unsigned IdxW      = idx_width(NumIn)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumIn-1:0]                   req_i,
  input  logic [NumIn-1:0][DataWidth-1:0]    data_i,
  input  logic                               advance_i,
  output logic [NumIn-1:0]                   gnt_o,
  output logic [IdxW-1:0]                    idx_o,
  output logic [DataWidth-1:0]               data_o
);

  // Last served index; resetting to the top entry makes requester 0 win first.
  logic [IdxW-1:0] last_q;

  // Scan cyclically from last_q+1. The grant stays locked while requesters hold
  // their request, because last_q only moves on an accepted handshake.
  always_comb begin
    int cand;
    logic found;
    cand   = 0;
    found  = 1'b0;
    gnt_o  = '0;
    idx_o  = '0;
    for (int k = 1; k <= int'(NumIn); k++) begin
      cand = int'(last_q) + k;
      if (cand >= int'(NumIn)) cand = cand - int'(NumIn);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = IdxW'(cand);
      end
    end
    if (found) gnt_o[idx_o] = 1'b1;
    data_o = data_i[idx_o];
  end

  // Priority pointer advances only when the granted request is taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        last_q <= IdxW'(NumIn - 1);
    else if (advance_i) last_q <= idx_o;
  end

endmodule

// File: rtl/instruction_fetch_responder.sv
// Serves instruction-cache line misses: arbitrates, fetches one instruction per beat
// from the shared instruction memory, and returns the assembled line to its requester.
module instruction_fetch_responder
  import instruction_fetch_responder_pkg::*;
#(
  parameter  int unsigned NumCus           = 8,
  parameter  int unsigned PcWidth          = 32,
  parameter  int unsigned EncInstWidth     = 32,
  parameter  int unsigned CachelineIdxBits = 1,
  localparam int unsigned Beats            = 1 << CachelineIdxBits,
  localparam int unsigned LineAddrW        = PcWidth - CachelineIdxBits
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NumCus-1:0]                      ic_req_i,
  output logic [NumCus-1:0]                      ic_ready_o,
  input  logic [NumCus-1:0][LineAddrW-1:0]       ic_addr_i,
  output logic [NumCus-1:0]                      ic_valid_o,
  output logic [Beats-1:0][EncInstWidth-1:0]     ic_data_o,
  output logic                                   mem_req_o,
  input  logic                                   mem_gnt_i,
  output logic [PcWidth-1:0]                     mem_addr_o,
  input  logic                                   mem_rvalid_i,
  input  logic [EncInstWidth-1:0]                mem_rdata_i
);

  localparam int unsigned CntW = cnt_width(Beats);
  localparam int unsigned OwnW = idx_width(NumCus);

  typedef logic [LineAddrW-1:0]                 cache_addr_t;
  typedef logic [Beats-1:0][EncInstWidth-1:0]   cache_data_t;

  state_e      state_q, state_d;
  logic [OwnW-1:0] owner_q, owner_d;
  cache_addr_t line_addr_q, line_addr_d;
  logic [CntW-1:0] issue_cnt_q, issue_cnt_d, recv_cnt_q, recv_cnt_d;
  cache_data_t line_q, line_d;

  logic [NumCus-1:0] arb_gnt;
  logic [OwnW-1:0]   arb_idx;
  cache_addr_t       arb_addr;
  logic              hs;

  // Ready is withheld while busy and while reset is asserted.
  assign ic_ready_o = arb_gnt & {NumCus{(state_q == IDLE) && rst_ni}};
  assign hs         = |ic_ready_o;

  instruction_fetch_responder_rr_arb #(
    .NumIn     (NumCus),
    .DataWidth (LineAddrW)
  ) i_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (ic_req_i),
    .data_i    (ic_addr_i),
    .advance_i (hs),
    .gnt_o     (arb_gnt),
    .idx_o     (arb_idx),
    .data_o    (arb_addr)
  );

  // Next-state and output logic for the IDLE -> FETCH -> RESPOND cycle.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    line_addr_d = line_addr_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    line_d      = line_q;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    ic_valid_o  = '0;
    ic_data_o   = '0;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          owner_d     = arb_idx;
          line_addr_d = arb_addr;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        // Address is fixed by issue_cnt_q, so it stays put until granted.
        mem_req_o = (issue_cnt_q < CntW'(Beats));
        if (mem_req_o)
          mem_addr_o = (PcWidth'(line_addr_q) << CachelineIdxBits) | PcWidth'(issue_cnt_q);
        if (mem_req_o && mem_gnt_i) issue_cnt_d = issue_cnt_q + CntW'(1);
        // Data returns in order, so the receive count is the beat index.
        if (mem_rvalid_i) begin
          for (int b = 0; b < int'(Beats); b++)
            if (recv_cnt_q == CntW'(b)) line_d[b] = mem_rdata_i;
          recv_cnt_d = recv_cnt_q + CntW'(1);
          if (recv_cnt_q == CntW'(Beats - 1)) state_d = RESPOND;
        end
      end
      RESPOND: begin
        ic_valid_o[owner_q] = 1'b1;
        ic_data_o           = line_q;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any line in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      line_addr_q <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      line_q      <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      line_addr_q <= line_addr_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      line_q      <= line_d;
    end
  end

  a_rvalid_state : assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i |-> (state_q == FETCH))
    else $fatal(1, "rvalid received outside FETCH");

  a_rvalid_cnt : assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i |-> (recv_cnt_q < issue_cnt_q))
    else $fatal(1, "rvalid without an outstanding beat");

  for (genvar g = 0; g < int'(NumCus); g++) begin : g_addr_chk
    a_addr_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (ic_req_i[g] && !ic_ready_o[g]) |=> $stable(ic_addr_i[g]))
      else $fatal(1, "cache address changed while waiting for ready");
  end

endmodule
